// File: rtl/collision_engine.sv
// D2Q9 lattice-Boltzmann BGK collision engine, one cell per handshake, shared restoring divider.
// Optional COLLISION_BOUNCEBACK_EN: solid cells return direction-reversed populations.
module collision_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic [9*DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [FRAC_W+1:0]   omega_in,
  input  logic                obstacle_in,
  output logic                valid_out,
  input  logic                ready_in,
  output logic [9*DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                busy_out
);

  localparam int unsigned RHO_W = DATA_W + 4;
  localparam int unsigned SUM_W = DATA_W + 3;
  localparam int unsigned DIV_W = RHO_W + FRAC_W;
  localparam int unsigned Q_W   = FRAC_W + 1;
  localparam int unsigned U_W   = FRAC_W + 2;
  localparam int unsigned EU_W  = FRAC_W + 3;
  localparam int unsigned SQ_W  = 2 * U_W;
  localparam int unsigned P_W   = 2 * FRAC_W + 9;
  localparam int unsigned RW_W  = RHO_W + 16;
  localparam int unsigned FEQ_W = RW_W + P_W + 1;
  localparam int unsigned ACC_W = FEQ_W + FRAC_W + 4;
  localparam int unsigned SH    = 16 + 2 * FRAC_W + 1;
  localparam int unsigned T     = SH + FRAC_W;
  localparam int unsigned CNT_W = $clog2(Q_W + 1);

  localparam int EX [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  localparam int EY [9] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};
  localparam int WT [9] = '{29127, 7282, 1820, 7282, 1820, 7282, 1820, 7282, 1820};

  typedef enum logic [2:0] {StIdle, StSum, StDivX, StDivY, StEq, StRelax, StDone} state_e;

  state_e                     state_q, state_d;
  logic                       armed_q;
  logic [DATA_W-1:0]          f_q [9];
  logic [DATA_W-1:0]          f_d [9];
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [FRAC_W+1:0]          omega_q, omega_d;
  logic [RHO_W-1:0]           rho_q, rho_d;
  logic                       sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [SUM_W-1:0]           sy_mag_q, sy_mag_d;
  logic [DIV_W-1:0]           rem_q, rem_d, dvs_q, dvs_d;
  logic [Q_W-2:0]             quo_q, quo_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [U_W-1:0]      ux_q, ux_d, uy_q, uy_d;
  logic signed [FEQ_W-1:0]    feq_q [9];
  logic signed [FEQ_W-1:0]    feq_d [9];
  logic [DATA_W-1:0]          dout_q [9];
  logic [DATA_W-1:0]          dout_d [9];

`ifdef COLLISION_BOUNCEBACK_EN
  localparam int OPP [9] = '{0, 5, 6, 7, 8, 1, 2, 3, 4};
  logic obs_q, obs_d;
`else
  logic unused_obstacle;
  assign unused_obstacle = obstacle_in;
`endif

  function automatic logic [SUM_W-1:0] mag(input logic signed [SUM_W-1:0] v);
    return v[SUM_W-1] ? -v : v;
  endfunction

  // Moment sums, combinational from the captured populations.
  logic [RHO_W-1:0]        rho_c;
  logic signed [SUM_W-1:0] sx_c, sy_c;
  always_comb begin
    rho_c = '0;
    for (int i = 0; i < 9; i++) rho_c = rho_c + RHO_W'(f_q[i]);
    sx_c = $signed(SUM_W'(f_q[2]) + SUM_W'(f_q[3]) + SUM_W'(f_q[4]))
         - $signed(SUM_W'(f_q[6]) + SUM_W'(f_q[7]) + SUM_W'(f_q[8]));
    sy_c = $signed(SUM_W'(f_q[8]) + SUM_W'(f_q[1]) + SUM_W'(f_q[2]))
         - $signed(SUM_W'(f_q[4]) + SUM_W'(f_q[5]) + SUM_W'(f_q[6]));
  end

  // One restoring step per cycle; divisor walks down from rho<<FRAC_W.
  logic                  ge;
  logic [DIV_W-1:0]      rem_step;
  logic [Q_W-1:0]        quo_step, quo_fin;
  logic signed [U_W-1:0] u_fin;
  always_comb begin
    ge       = rem_q >= dvs_q;
    rem_step = ge ? rem_q - dvs_q : rem_q;
    quo_step = {quo_q, ge};
    quo_fin  = (rho_q == '0) ? '0 : quo_step;
    if ((state_q == StDivX) ? sx_neg_q : sy_neg_q) u_fin = -$signed({1'b0, quo_fin});
    else u_fin = $signed({1'b0, quo_fin});
  end

  // Equilibrium: feq scaled by 2^SH, polynomial held as 2P at scale 2^(2*FRAC_W).
  logic signed [SQ_W-1:0] usq_c;
  always_comb begin
    logic signed [SQ_W-1:0]  ux_w, uy_w;
    logic signed [EU_W-1:0]  eu;
    logic signed [P_W-1:0]   eu_w, eu2_w, usq_w, p2;
    logic [RW_W-1:0]         rw;
    ux_w  = SQ_W'(ux_q);
    uy_w  = SQ_W'(uy_q);
    usq_c = ux_w * ux_w + uy_w * uy_w;
    usq_w = P_W'(usq_c);
    for (int i = 0; i < 9; i++) begin
      eu = '0;
      if (EX[i] == 1) eu = eu + EU_W'(ux_q);
      else if (EX[i] == -1) eu = eu - EU_W'(ux_q);
      if (EY[i] == 1) eu = eu + EU_W'(uy_q);
      else if (EY[i] == -1) eu = eu - EU_W'(uy_q);
      eu_w  = P_W'(eu);
      eu2_w = eu_w * eu_w;
      p2    = (P_W'(1) <<< (2 * FRAC_W + 1)) + P_W'(6) * (eu_w <<< FRAC_W)
            + P_W'(9) * eu2_w - P_W'(3) * usq_w;
      rw    = RW_W'(rho_q) * RW_W'(WT[i]);
      feq_d[i] = FEQ_W'($signed({1'b0, rw})) * FEQ_W'(p2);
    end
  end

  // Relaxation with round-half-up and saturation.
  logic [DATA_W-1:0] relax_c [9];
  always_comb begin
    logic signed [ACC_W-1:0] fs, d, res;
    for (int i = 0; i < 9; i++) begin
      fs  = ACC_W'($signed({1'b0, f_q[i]}));
      d   = ACC_W'(feq_q[i]) - (fs <<< SH);
      res = ((fs <<< T) + ACC_W'($signed({1'b0, omega_q})) * d
            + (ACC_W'(1) <<< (T - 1))) >>> T;
      if (res[ACC_W-1]) relax_c[i] = '0;
      else if (|res[ACC_W-2:DATA_W]) relax_c[i] = '1;
      else relax_c[i] = res[DATA_W-1:0];
`ifdef COLLISION_BOUNCEBACK_EN
      if (obs_q) relax_c[i] = f_q[OPP[i]];
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    f_d      = f_q;
    addr_d   = addr_q;
    omega_d  = omega_q;
    rho_d    = rho_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    sy_mag_d = sy_mag_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    ux_d     = ux_q;
    uy_d     = uy_q;
    dout_d   = dout_q;
`ifdef COLLISION_BOUNCEBACK_EN
    obs_d    = obs_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_in && armed_q) begin
          for (int i = 0; i < 9; i++) f_d[i] = data_in[i*DATA_W +: DATA_W];
          addr_d  = addr_in;
          omega_d = omega_in;
`ifdef COLLISION_BOUNCEBACK_EN
          obs_d   = obstacle_in;
`endif
          state_d = StSum;
        end
      end
      StSum: begin
        rho_d    = rho_c;
        sx_neg_d = sx_c[SUM_W-1];
        sy_neg_d = sy_c[SUM_W-1];
        sy_mag_d = mag(sy_c);
        rem_d    = DIV_W'(mag(sx_c)) << FRAC_W;
        dvs_d    = DIV_W'(rho_c) << FRAC_W;
        quo_d    = '0;
        cnt_d    = CNT_W'(FRAC_W);
        state_d  = StDivX;
      end
      StDivX, StDivY: begin
        rem_d = rem_step;
        dvs_d = dvs_q >> 1;
        quo_d = quo_step[Q_W-2:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (state_q == StDivX) begin
            ux_d    = u_fin;
            rem_d   = DIV_W'(sy_mag_q) << FRAC_W;
            dvs_d   = DIV_W'(rho_q) << FRAC_W;
            quo_d   = '0;
            cnt_d   = CNT_W'(FRAC_W);
            state_d = StDivY;
          end else begin
            uy_d    = u_fin;
            state_d = StEq;
          end
        end
      end
      StEq:    state_d = StRelax;
      StRelax: begin
        dout_d  = relax_c;
        state_d = StDone;
      end
      StDone:  if (ready_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      armed_q  <= 1'b0;
      addr_q   <= '0;
      omega_q  <= '0;
      rho_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      sy_mag_q <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      ux_q     <= '0;
      uy_q     <= '0;
`ifdef COLLISION_BOUNCEBACK_EN
      obs_q    <= 1'b0;
`endif
      for (int i = 0; i < 9; i++) begin
        f_q[i]    <= '0;
        feq_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      addr_q   <= addr_d;
      omega_q  <= omega_d;
      rho_q    <= rho_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      sy_mag_q <= sy_mag_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      ux_q     <= ux_d;
      uy_q     <= uy_d;
`ifdef COLLISION_BOUNCEBACK_EN
      obs_q    <= obs_d;
`endif
      for (int i = 0; i < 9; i++) begin
        f_q[i]    <= f_d[i];
        dout_q[i] <= dout_d[i];
        if (state_q == StEq) feq_q[i] <= feq_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) data_out[i*DATA_W +: DATA_W] = dout_q[i];
  end

  assign addr_out  = addr_q;
  assign ready_out = (state_q == StIdle) && armed_q;
  assign valid_out = (state_q == StDone);
  assign busy_out  = (state_q != StIdle);

endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine: table of hand-computed cells plus back-pressure/reset cases.
module tb_collision_engine;

  logic        clk, rst_n, valid_in, ready_out, obstacle_in, valid_out, ready_in, busy_out;
  logic [71:0] data_in, data_out;
  logic [15:0] addr_in, addr_out;
  logic [9:0]  omega_in;
  int          total, bad;

  collision_engine dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .data_in     (data_in),
    .addr_in     (addr_in),
    .omega_in    (omega_in),
    .obstacle_in (obstacle_in),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .data_out    (data_out),
    .addr_out    (addr_out),
    .busy_out    (busy_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [71:0] d;
    logic [9:0]  om;
    logic [15:0] a;
    logic        obs;
    logic [71:0] e;
    int          tol;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [71:0] p9(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    return {8'(v8), 8'(v7), 8'(v6), 8'(v5), 8'(v4), 8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  task automatic chk(input string name, input longint got, input longint want, input int tol);
    total++;
    if (got > want + tol || got < want - tol) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic send(input logic [71:0] d, input logic [9:0] om, input logic [15:0] a,
                      input logic obs);
    int n;
    n = 0;
    while (!ready_out && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready_out) chk("ready_wait", 0, 1, 0);
    data_in     = d;
    omega_in    = om;
    addr_in     = a;
    obstacle_in = obs;
    valid_in    = 1'b1;
    @(posedge clk);
    #1;
    valid_in    = 1'b0;
    obstacle_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat, vcnt;
    logic [71:0] rest;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    obstacle_in = 1'b0;
    data_in = '0;
    addr_in = '0;
    omega_in = '0;
    rest = p9(16, 4, 1, 4, 1, 4, 1, 4, 1);

    vecs[0] = '{rest, 10'd256, 16'h0001, 1'b0, rest, 0};
    vecs[1] = '{p9(10, 20, 30, 40, 50, 60, 70, 80, 90), 10'd0, 16'h1234, 1'b0,
                p9(10, 20, 30, 40, 50, 60, 70, 80, 90), 0};
    vecs[2] = '{p9(0, 0, 0, 0, 0, 0, 0, 0, 0), 10'd256, 16'h00ff, 1'b0,
                p9(0, 0, 0, 0, 0, 0, 0, 0, 0), 0};
    vecs[3] = '{p9(0, 255, 0, 0, 0, 0, 0, 0, 0), 10'd509, 16'h0a0a, 1'b0,
                p9(0, 142, 99, 0, 14, 56, 14, 0, 99), 1};
    vecs[4] = '{p9(0, 0, 0, 0, 0, 0, 0, 10, 0), 10'd256, 16'h0004, 1'b0,
                p9(0, 0, 0, 1, 0, 0, 2, 8, 2), 0};
    vecs[5] = '{p9(0, 60, 0, 30, 0, 0, 0, 0, 0), 10'd256, 16'h0005, 1'b0,
                p9(7, 41, 19, 17, 0, 2, 4, 0, 4), 0};
    vecs[6] = '{p9(0, 0, 0, 0, 0, 20, 0, 0, 0), 10'd128, 16'h0006, 1'b0,
                p9(0, 1, 0, 0, 2, 18, 2, 0, 0), 0};
    vecs[7] = '{p9(255, 255, 255, 255, 255, 255, 255, 255, 255), 10'd256, 16'hffff, 1'b0,
                p9(255, 255, 64, 255, 64, 255, 64, 255, 64), 0};
`ifdef COLLISION_BOUNCEBACK_EN
    vecs[8] = '{p9(0, 1, 2, 3, 4, 5, 6, 7, 8), 10'd0, 16'h0008, 1'b1,
                p9(0, 5, 6, 7, 8, 1, 2, 3, 4), 0};
`else
    vecs[8] = '{p9(0, 1, 2, 3, 4, 5, 6, 7, 8), 10'd0, 16'h0008, 1'b1,
                p9(0, 1, 2, 3, 4, 5, 6, 7, 8), 0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst ready_out", ready_out, 0, 0);
    chk("rst valid_out", valid_out, 0, 0);
    chk("rst busy_out", busy_out, 0, 0);
    chk("rst data_out", data_out, 0, 0);
    chk("rst addr_out", addr_out, 0, 0);
    rst_n = 1'b1;
    chk("ready before edge", ready_out, 0, 0);
    @(posedge clk);
    #1;
    chk("ready after edge", ready_out, 1, 0);

    for (int v = 0; v < 9; v++) begin
      send(vecs[v].d, vecs[v].om, vecs[v].a, vecs[v].obs);
      chk($sformatf("v%0d busy", v), busy_out, 1, 0);
      wait_valid(lat);
      chk($sformatf("v%0d latency", v), lat, 21, 0);
      chk($sformatf("v%0d ready_low", v), ready_out, 0, 0);
      chk($sformatf("v%0d addr", v), addr_out, vecs[v].a, 0);
      for (int i = 0; i < 9; i++)
        chk($sformatf("v%0d f%0d", v, i), data_out[i*8 +: 8], vecs[v].e[i*8 +: 8], vecs[v].tol);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d back_idle", v), ready_out, 1, 0);
      chk($sformatf("v%0d valid_drop", v), valid_out, 0, 0);
    end

    // Back-pressure: DONE holds for five cycles while stray valids are ignored.
    ready_in = 1'b0;
    send(rest, 10'd256, 16'hbeef, 1'b0);
    wait_valid(lat);
    chk("bp latency", lat, 21, 0);
    for (int c = 0; c < 5; c++) begin
      data_in  = p9(c, 200, 7, 9, 11, 13, 15, 17, 19);
      addr_in  = 16'h5555;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d valid", c), valid_out, 1, 0);
      chk($sformatf("bp%0d ready", c), ready_out, 0, 0);
      chk($sformatf("bp%0d data", c), data_out, rest, 0);
      chk($sformatf("bp%0d addr", c), addr_out, 16'hbeef, 0);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release valid", valid_out, 0, 0);
    chk("bp release busy", busy_out, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp no stray accept", busy_out, 0, 0);

    // Reset during DIVY aborts the cell.
    send(vecs[3].d, vecs[3].om, 16'h7777, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort busy before", busy_out, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("abort valid", valid_out, 0, 0);
    chk("abort busy", busy_out, 0, 0);
    chk("abort ready", ready_out, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (valid_out) vcnt++;
    end
    chk("abort no result", vcnt, 0, 0);
    chk("abort ready again", ready_out, 1, 0);

    send(vecs[5].d, vecs[5].om, 16'h4321, 1'b0);
    wait_valid(lat);
    chk("post-reset latency", lat, 21, 0);
    chk("post-reset f1", data_out[15:8], 41, 0);
    chk("post-reset addr", addr_out, 16'h4321, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_engine.md
Name: collision_engine

Overview:
- Parametrised D2Q9 lattice-Boltzmann BGK collision engine for one lattice cell at a time.
- Takes the 9 population densities of a cell read from BRAM and computes rho, ux and uy. A single shared iterative divider produces the velocities.
- Forms the equilibrium populations, relaxes the inputs toward them by a runtime omega, and returns saturated densities for write-back to the same address.
- Sits between the lattice BRAM read port and the write-back port, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 8: width of one population density (unsigned).
- FRAC_W, 8: fraction bits of the velocity and omega fixed-point formats.
- ADDR_W, 16: width of the cell address/tag passed through with the data.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- valid_in  input  1  upstream cell data valid.
- ready_out  output  1  engine can accept a cell.
- data_in  input  9xDATA_W  populations. Index order: 0 centre, 1 N, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW.
- addr_in  input  ADDR_W  cell address, captured with data_in.
- omega_in  input  FRAC_W+2  relaxation rate, unsigned Q2.FRAC_W, range 0 to just under 2.0. Captured on accept.
- obstacle_in  input  1  cell is a solid node; used only with BOUNCEBACK_EN.
- valid_out  output  1  data_out and addr_out valid.
- ready_in  input  1  downstream accepts the result.
- data_out  output  9xDATA_W  post-collision populations, same index order as data_in.
- addr_out  output  ADDR_W  captured addr_in.
- busy_out  output  1  high in every state except IDLE.

Behaviour:
- Reset values: ready_out=0, valid_out=0, busy_out=0, data_out=0, addr_out=0, FSM in IDLE.
- ready_out rises on the first clk_in edge after rst_n_in deasserts. Asserting reset in any state aborts the cell in flight; no output is produced for it.
- FSM: IDLE -> SUM -> DIVX -> DIVY -> EQ -> RELAX -> DONE -> IDLE.
- IDLE: ready_out=1. On valid_in&&ready_out, capture data_in, addr_in, omega_in and obstacle_in; go to SUM.
- SUM (1 cycle):
  - rho = sum of all 9 populations, DATA_W+4 bits.
  - sum_x = f2+f3+f4-f6-f7-f8, signed.
  - sum_y = f8+f1+f2-f4-f5-f6, signed.
- DIVX / DIVY (FRAC_W+1 cycles each): one shared restoring divider.
  - Divides |sum|<<FRAC_W by rho, then applies the sign.
  - Result ux, uy is signed Q1.FRAC_W, |u| <= 1.0.
  - If rho==0, the quotient is forced to 0. Cycle count is unchanged.
- EQ (1 cycle):
  - Computes e.u for each direction, (e.u)^2, and usq = ux^2+uy^2.
  - Computes the weighted density rho*w. Weights are Q0.16 constants: 4/9=29127, 1/9=7282, 1/36=1820.
  - feq_i = rho*w_i*(1 + 3(e.u) + 4.5(e.u)^2 - 1.5usq).
  - All intermediate values are kept at full width; no intermediate truncation.
- RELAX (1 cycle):
  - f_out_i = f_i + omega*(feq_i - f_i).
  - Round to nearest (half up) to integer.
  - Saturate to the range 0 .. 2^DATA_W-1.
- DONE: valid_out=1; data_out and addr_out held stable.
  - On ready_in=1, go to IDLE next cycle.
  - While ready_in=0, hold all outputs; ready_out=0.
- Latency from the accept edge to valid_out rising: 2*FRAC_W+5 cycles (21 at default). Latency is fixed and independent of the data.
- Throughput: one cell per 2*FRAC_W+7 cycles with no back-pressure.
- ready_out is never asserted in the same cycle as valid_out.

Optional Feature:
- Macro: COLLISION_BOUNCEBACK_EN.
- Defined: a cell captured with obstacle_in=1 skips the arithmetic and outputs the opposite-direction populations:
  - data_out[0]=f0.
  - data_out[1..8] = f5, f6, f7, f8, f1, f2, f3, f4.
  - The same FSM path and latency are used.
- Undefined: obstacle_in is ignored and every cell is collided.

Test Plan:
- Rest-state fixpoint: data_in={16,4,1,4,1,4,1,4,1}, omega=256 (1.0) -> data_out identical to data_in; valid_out rises 21 cycles after accept.
- Zero omega: data_in={10,20,30,40,50,60,70,80,90}, omega=0 -> data_out==data_in exactly; addr_in=0x1234 -> addr_out=0x1234.
- Empty cell: all data_in=0, omega=256 -> data_out all 0; latency still 21; FSM returns to IDLE and accepts the next cell.
- Strong flow with saturation: data_in[1]=255, others 0, omega=509:
  - data_out[0]=0 (clamped low).
  - data_out[1]=142±1.
  - data_out[5]=56±1.
- Back-pressure and reset:
  - Hold ready_in=0 for 5 cycles in DONE -> data_out stable, ready_out=0, valid_in pulses ignored.
  - Pull rst_n_in low during DIVY -> valid_out=0 immediately; no result for the aborted cell.
- Bounce-back (COLLISION_BOUNCEBACK_EN defined): obstacle_in=1, data_in={0,1,2,3,4,5,6,7,8} -> data_out={0,5,6,7,8,1,2,3,4}.
